// File: rtl/led_pattern_engine.sv
// -----------------------------------------------------------------------------
// led_pattern_engine
//
// Purpose:
//   Board LED pattern generator. A programmable step divider advances one of
//   five patterns: bounce, rotate left, rotate right, bar fill and blink.
//   The divider and pattern can be frozen. One-cycle status pulses mark each
//   new LED value and each return to the pattern's start value.
//
// Parameters:
//   LED_WIDTH  number of LEDs (2..32)
//   DIV_WIDTH  width of the step-period counter
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   en          1 = run, 0 = freeze divider and pattern
//   mode        pattern select, sampled only at step boundaries
//               (0 bounce, 1 rotl, 2 rotr, 3 bar, 4 blink, 5-7 -> bounce)
//   period      step interval minus one
//   led_data    LED drive, 1 = lit (registered)
//   dir         1 = current motion toward MSB (registered)
//   step_tick   pulse in the first cycle a new led_data value is visible
//   cycle_done  pulse in the first cycle led_data returns to the start value
// -----------------------------------------------------------------------------
module led_pattern_engine #(
   parameter int LED_WIDTH = 8,
   parameter int DIV_WIDTH = 24
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [2:0]           mode,
   input  logic [DIV_WIDTH-1:0] period,
   output logic [LED_WIDTH-1:0] led_data,
   output logic                 dir,
   output logic                 step_tick,
   output logic                 cycle_done
);

   typedef enum logic [2:0] {
      PAT_BOUNCE = 3'd0,
      PAT_ROTL   = 3'd1,
      PAT_ROTR   = 3'd2,
      PAT_BAR    = 3'd3,
      PAT_BLINK  = 3'd4
   } pat_t;

   localparam logic [LED_WIDTH-1:0] LSB_ONE  = LED_WIDTH'(1);
   localparam logic [LED_WIDTH-1:0] MSB_ONE  = LSB_ONE << (LED_WIDTH - 1);
   localparam logic [LED_WIDTH-1:0] ALL_ONES = '1;

   function automatic logic [LED_WIDTH-1:0] start_led(input pat_t m);
      case (m)
         PAT_ROTR:  start_led = MSB_ONE;
         PAT_BAR:   start_led = '0;
         PAT_BLINK: start_led = ALL_ONES;
         default:   start_led = LSB_ONE;
      endcase
   endfunction

   // Only rotate right starts moving toward the LSB.
   function automatic logic start_dir(input pat_t m);
      start_dir = (m != PAT_ROTR);
   endfunction

   logic [DIV_WIDTH-1:0] cnt_q,  cnt_d;
   pat_t                 mode_q, mode_d;
   logic [LED_WIDTH-1:0] led_q,  led_d;
   logic                 dir_q,  dir_d;
   logic                 step_q, step_d;
   logic                 done_q, done_d;
   logic                 hit;
   pat_t                 eff;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         mode_q <= PAT_BOUNCE;
         led_q  <= LSB_ONE;
         dir_q  <= 1'b1;
         step_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         mode_q <= mode_d;
         led_q  <= led_d;
         dir_q  <= dir_d;
         step_q <= step_d;
         done_q <= done_d;
      end
   end

   // Next-state logic
   always_comb begin
      // >= rather than == so lowering period below cnt steps on the next edge.
      hit    = en && (cnt_q >= period);
      eff    = (mode > 3'd4) ? PAT_BOUNCE : pat_t'(mode);
      cnt_d  = cnt_q;
      mode_d = mode_q;
      led_d  = led_q;
      dir_d  = dir_q;
      step_d = 1'b0;
      done_d = 1'b0;

      if (hit) begin
         cnt_d  = '0;
         step_d = 1'b1;
         if (eff != mode_q) begin
            // Pattern change: load the new start value; this is not a wrap.
            mode_d = eff;
            led_d  = start_led(eff);
            dir_d  = start_dir(eff);
         end else begin
            case (mode_q)
               PAT_BOUNCE: begin
                  // Endpoints are turned around, not repeated.
                  if (dir_q) begin
                     if (led_q[LED_WIDTH-1]) begin
                        led_d = MSB_ONE >> 1;
                        dir_d = 1'b0;
                     end else begin
                        led_d = led_q << 1;
                     end
                  end else begin
                     if (led_q[0]) begin
                        led_d = LSB_ONE << 1;
                        dir_d = 1'b1;
                     end else begin
                        led_d = led_q >> 1;
                     end
                  end
               end
               PAT_ROTL:  led_d = {led_q[LED_WIDTH-2:0], led_q[LED_WIDTH-1]};
               PAT_ROTR:  led_d = {led_q[0], led_q[LED_WIDTH-1:1]};
               PAT_BAR:   led_d = (&led_q) ? '0 : {led_q[LED_WIDTH-2:0], 1'b1};
               PAT_BLINK: led_d = ~led_q;
               default:   led_d = LSB_ONE;
            endcase
            done_d = (led_d == start_led(mode_q));
         end
      end else if (en) begin
         cnt_d = cnt_q + DIV_WIDTH'(1);
      end
   end

   // Outputs
   always_comb begin
      led_data   = led_q;
      dir        = dir_q;
      step_tick  = step_q;
      cycle_done = done_q;
   end

endmodule

// File: doc/led_pattern_engine.md
# led_pattern_engine

Parametrised LED pattern generator, successor to the board's fixed 8-bit bouncing "water" LED driver. It adds:
- arbitrary LED width;
- a runtime step period;
- five selectable patterns (bounce, rotate left, rotate right, bar fill, blink);
- enable/freeze;
- status pulses for step and pattern wrap.

It sits at the top level beside the front-end pipeline and drives the board LEDs directly.

## Interface
- LED_WIDTH, 8, number of LEDs; legal range 2..32.
- DIV_WIDTH, 24, width of the step-period counter.

- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  1 = run; 0 = freeze divider and pattern.
- mode  input  3  pattern select, sampled only at step boundaries:
  - 0 bounce; 1 rotate left; 2 rotate right; 3 bar fill; 4 blink;
  - 5-7 reserved, mapped to 0.
- period  input  DIV_WIDTH  step interval minus one; one step every period+1 enabled cycles.
- led_data  output  LED_WIDTH  LED drive, 1 = lit.
- dir  output  1  1 = current motion toward MSB.
- step_tick  output  1  one-cycle pulse, high in the first cycle a new led_data value is visible.
- cycle_done  output  1  one-cycle pulse, high in the first cycle led_data returns to the pattern start value.

## Operation
- Divider: cnt (DIV_WIDTH bits).
  - hit = en && (cnt >= period).
  - On hit: cnt <= 0. Else if en: cnt <= cnt+1. Else cnt holds.
  - `>=` makes lowering period below the current cnt fire on the next edge.
  - period = 0 steps every enabled cycle.
- Mode register cur_mode (reset 0). On hit, eff = (mode > 4) ? 0 : mode.
  - eff != cur_mode: reinit step. cur_mode <= eff; led_data <= start value of eff; dir <= start dir; step_tick fires; cycle_done does not fire.
  - eff == cur_mode: advance step. led_data <= next value per pattern below.
- Start values (led_data / dir):
  - bounce: 0..01 / 1.
  - rotate left: 0..01 / 1.
  - rotate right: 10..0 / 0.
  - bar fill: all zeros / 1.
  - blink: all ones / 1.
- Bounce: one lit bit.
  - dir=1: shift left. At MSB, next is MSB>>1 and dir <= 0.
  - dir=0: shift right. At bit0, next is bit1 and dir <= 1.
  - Endpoints are not repeated; period is 2*(LED_WIDTH-1) steps.
- Rotate left/right: circular shift by one; period LED_WIDTH steps.
- Bar fill: next = {led_data[W-2:0],1'b1} until all ones; all ones -> all zeros. Period LED_WIDTH+1 steps.
- Blink: next = ~led_data; period 2 steps.
- cycle_done: pulses on an advance step whose next value equals the cur_mode start value.
- Only the patterns above are legal; led_data never holds any other value.

## Timing
- All outputs are registered.
- Reset values: led_data = 0..01, dir = 1, step_tick = 0, cycle_done = 0, cnt = 0, cur_mode = 0.
- Reset wins over en and hit in the same cycle. Reset mid-step discards the partial count.
- Latency:
  - Hit at edge k: led_data, dir, step_tick and cycle_done update at edge k.
  - Pulses are high for exactly one cycle (k to k+1) unless the next cycle is also a hit (period = 0), in which case step_tick stays high.
- With en held high and a constant period P, consecutive step_tick pulses are exactly P+1 cycles apart.
- en low:
  - cnt, led_data, dir and cur_mode hold.
  - step_tick and cycle_done are 0.
  - Counting resumes from the held cnt.
- mode and period changes between hits have no effect on led_data until the next hit. period affects only the hit comparison.

## Test plan
- Bounce, W=8, P=3, en=1 after reset: led_data steps every 4 cycles through 01,02,04,…,80,40,…,01. dir falls with 40. cycle_done is high only with the 14th-step 01.
- Bar fill: set mode=3 from bounce. First hit loads 00 with no cycle_done. Sequence then runs 01,03,07,…,FF,00, with cycle_done on the 9th advance (00).
- Mid-run mode switch: bounce at 08, set mode=2. Next hit shows 80 with dir=0 and step_tick=1. Next hit shows 40. mode=6 later reinitialises to bounce 01.
- Freeze: en=0 for 10 cycles with cnt=2, led_data=10. Outputs hold and no pulses occur. After en=1, the next step occurs 2 cycles later (P=3).
- Period boundaries:
  - cnt=5, P changed from 9 to 2: hit on the next edge.
  - P=0: led_data advances every cycle and step_tick stays high continuously.
- Reset mid-run in blink with mode=4 held: led_data=01, dir=1, pulses 0. First hit after reset reinitialises to FF without cycle_done.
